tw_mul_stage: RTL and testbench

Pipelined twiddle-multiply stage that sits directly upstream of the NTT butterfly. It multiplies the lower operand by a twiddle factor modulo q = 12289 using Barrett reduction, and delays the upper operand by the same amount, so the butterfly receives a time-aligned (u, w·v mod q) pair. A bypass input passes the lower operand unmultiplied with identical latency, so the same stage serves passes that need no pre-multiply.

---
 rtl/ntt_pkg.sv | 12 +
 rtl/tw_mul_stage_if.sv | 25 ++
 rtl/barrett_reduce.sv | 42 ++++
 rtl/tw_mul_stage.sv | 60 ++++++
 tb/tb_tw_mul_stage.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT arithmetic constants for q = 12289
package ntt_pkg;
    localparam int DATA_WIDTH = 14;
    localparam int Q          = 12289;
    localparam int BARRETT_M  = 21843;
    localparam int BARRETT_K  = 28;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int R0_WIDTH   = 16;
    localparam int QHAT_WIDTH = 15;

    typedef logic [DATA_WIDTH-1:0] coeff_t;
endpackage

// File: rtl/tw_mul_stage_if.sv
// rtl/tw_mul_stage_if.sv - operand/result bundle between the twiddle stage and its neighbours
interface tw_mul_stage_if
    import ntt_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
);
    logic                  in_valid;
    logic                  byp;
    logic [data_width-1:0] a;
    logic [data_width-1:0] b;
    logic [data_width-1:0] w;
    logic                  out_valid;
    logic [data_width-1:0] a_out;
    logic [data_width-1:0] b_out;

    modport master (
        output in_valid, byp, a, b, w,
        input  out_valid, a_out, b_out
    );

    modport slave (
        input  in_valid, byp, a, b, w,
        output out_valid, a_out, b_out
    );
endinterface

// File: rtl/barrett_reduce.sv
// rtl/barrett_reduce.sv - two-cycle Barrett reduction of a 28-bit value modulo q
module barrett_reduce
    import ntt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PROD_WIDTH-1:0] x_i,
    output logic [DATA_WIDTH-1:0] r_o
);
    logic [QHAT_WIDTH-1:0] qhat;
    logic [PROD_WIDTH-1:0] qq;
    logic [R0_WIDTH-1:0]   r0_d, r0_q;
    logic [DATA_WIDTH-1:0] r_d, r_q;

    // qhat underestimates x/q by at most 2, so r0 stays below 3q and fits 16 bits.
    always_comb begin
        qhat = QHAT_WIDTH'((43'(x_i) * 43'(BARRETT_M)) >> BARRETT_K);
        qq   = PROD_WIDTH'(qhat) * PROD_WIDTH'(Q);
        r0_d = R0_WIDTH'(x_i - qq);
    end

    always_comb begin
        r_d = DATA_WIDTH'(r0_q);
        if (r0_q >= R0_WIDTH'(2 * Q)) begin
            r_d = DATA_WIDTH'(r0_q - R0_WIDTH'(2 * Q));
        end else if (r0_q >= R0_WIDTH'(Q)) begin
            r_d = DATA_WIDTH'(r0_q - R0_WIDTH'(Q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_q <= '0;
            r_q  <= '0;
        end else begin
            r0_q <= r0_d;
            r_q  <= r_d;
        end
    end

    assign r_o = r_q;
endmodule

// File: rtl/tw_mul_stage.sv
// rtl/tw_mul_stage.sv - 4-cycle twiddle multiply (b*w mod q) with a time-aligned a lane and bypass
module tw_mul_stage
    import ntt_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
)(
    input  logic           clk,
    input  logic           rst,
    tw_mul_stage_if.slave  io
);
    localparam int STAGES = 4;

    logic [data_width-1:0]   a_q   [STAGES];
    logic [data_width-1:0]   b_q   [STAGES];
    logic                    byp_q [STAGES];
    logic                    vld_q [STAGES];
    logic [data_width-1:0]   w_q;
    logic [2*data_width-1:0] prod_d, prod_q;
    logic [DATA_WIDTH-1:0]   red;

    assign prod_d = (2*data_width)'(b_q[0]) * (2*data_width)'(w_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                byp_q[i] <= 1'b0;
                vld_q[i] <= 1'b0;
            end
            w_q    <= '0;
            prod_q <= '0;
        end else begin
            a_q[0]   <= io.a;
            b_q[0]   <= io.b;
            byp_q[0] <= io.byp;
            vld_q[0] <= io.in_valid;
            w_q      <= io.w;
            for (int i = 1; i < STAGES; i++) begin
                a_q[i]   <= a_q[i-1];
                b_q[i]   <= b_q[i-1];
                byp_q[i] <= byp_q[i-1];
                vld_q[i] <= vld_q[i-1];
            end
            prod_q <= prod_d;
        end
    end

    barrett_reduce u_reduce (
        .clk (clk),
        .rst (rst),
        .x_i (PROD_WIDTH'(prod_q)),
        .r_o (red)
    );

    // Reduced product and bypass lane are both register outputs of S4; only the select mux follows.
    assign io.out_valid = vld_q[STAGES-1];
    assign io.a_out     = a_q[STAGES-1];
    assign io.b_out     = byp_q[STAGES-1] ? b_q[STAGES-1] : data_width'(red);
endmodule

// File: tb/tb_tw_mul_stage.sv
// tb/tb_tw_mul_stage.sv - scoreboard bench for tw_mul_stage
module tb_tw_mul_stage;
    import ntt_pkg::*;

    typedef struct {
        bit          v;
        bit          chk;
        logic [13:0] a;
        logic [13:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    tw_mul_stage_if #(.data_width(14)) bus ();

    tw_mul_stage #(.data_width(14)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        check("no_x", 14'($isunknown({bus.out_valid, bus.a_out, bus.b_out})), 14'd0);
        if (sb.size() == 4) begin
            e = sb.pop_front();
            check("out_valid", 14'(bus.out_valid), 14'(e.v));
            if (e.chk) begin
                check("a_out", bus.a_out, e.a);
                check("b_out", bus.b_out, e.b);
            end
        end
    endtask

    task automatic drive(input bit v, input bit by, input int av, input int bv, input int wv);
        exp_t e;
        bus.in_valid = v;
        bus.byp      = by;
        bus.a        = 14'(av);
        bus.b        = 14'(bv);
        bus.w        = 14'(wv);
        e.v   = v;
        e.chk = v;
        e.a   = 14'(av);
        e.b   = by ? 14'(bv) : 14'((bv * wv) % Q);
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Reset with a valid input present: the input must be dropped and the pipe filled with zeros.
    task automatic do_reset();
        exp_t z;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.byp      = 1'b0;
        bus.a        = 14'd77;
        bus.b        = 14'd3;
        bus.w        = 14'd4;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        check("rst_valid", 14'(bus.out_valid), 14'd0);
        check("rst_a", bus.a_out, 14'd0);
        check("rst_b", bus.b_out, 14'd0);
        z.v = 1'b0; z.chk = 1'b1; z.a = '0; z.b = '0;
        for (int i = 0; i < 3; i++) sb.push_back(z);
    endtask

    initial begin
        int bv, wv;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.byp      = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.w        = '0;
        do_reset();
        do_reset();

        drive(1, 0, 101, 2, 3);
        drive(1, 0, 102, 12288, 12288);
        drive(1, 0, 103, 12288, 2);
        drive(1, 0, 104, 1234, 5678);
        drive(1, 0, 105, 0, 9999);
        drive(1, 1, 106, 5000, 7);
        drive(1, 0, 107, 5000, 7);
        drive(1, 0, 108, 16383, 16383);
        drive(1, 1, 109, 16383, 5);
        drive(0, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            bv = int'($urandom_range(Q - 1));
            wv = int'($urandom_range(Q - 1));
            drive(1, 0, 200 + i, bv, wv);
        end
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            bv = int'($urandom_range(Q - 1));
            wv = int'($urandom_range(Q - 1));
            drive(1, 0, 300 + i, bv, wv);
        end

        drive(1, 0, 401, 11, 12);
        drive(1, 1, 402, 13, 14);
        drive(1, 0, 403, 15, 16);
        do_reset();
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
        drive(1, 0, 500, 9, 9);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            bv = int'($urandom_range(Q - 1));
            wv = int'($urandom_range(Q - 1));
            drive(($urandom_range(3) != 0), 1'($urandom_range(1)), int'($urandom_range(16383)), bv, wv);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
